data_producer: RTL and testbench

- AXI-Stream packet generator sitting directly upstream of the stream sink, driving its AXIS_RX_* inputs.
- On a start pulse it emits a programmed number of packets of programmed byte length, with a deterministic, checkable data pattern.
- Last-beat empty-byte count goes on TUSER.
- Obeys TREADY backpressure and inserts a configurable idle gap between packets.

---
 rtl/data_producer.sv | 107 ++++++++++
 tb/tb_data_producer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_producer.sv
// AXI-Stream packet generator: emits a programmed number of fixed-length packets
// whose 32-bit lanes carry a per-run beat sequence number.
module data_producer #(
    parameter int unsigned DW         = 128,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [15:0]   packet_bytes,
    input  logic [31:0]   packet_count,
    output logic          busy,
    output logic          done,
    output logic [31:0]   packets_sent,
    output logic [DW-1:0] AXIS_TX_TDATA,
    output logic [4:0]    AXIS_TX_TUSER,
    output logic          AXIS_TX_TLAST,
    output logic          AXIS_TX_TVALID,
    input  logic          AXIS_TX_TREADY
);

    localparam int unsigned BPB   = DW / 8;
    localparam int unsigned LANES = DW / 32;

    typedef enum logic [1:0] {StIdle, StSend, StGap, StFin} state_e;

    state_e      state_q, state_d;
    logic [15:0] nb_q;
    logic [15:0] beat_q;
    logic [4:0]  empty_q;
    logic [31:0] count_q;
    logic [31:0] seq_q;
    logic [31:0] sent_q;
    logic [31:0] gap_q;
    logic        start_ok;
    logic        hs;
    logic        last_beat;
    logic        last_pkt;

    assign start_ok  = start && (packet_bytes != 16'd0) && (packet_count != 32'd0);
    assign hs        = (state_q == StSend) && AXIS_TX_TREADY;
    assign last_beat = (beat_q == nb_q - 16'd1);
    assign last_pkt  = (sent_q + 32'd1 == count_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // A zero-sized request still completes, just without any beats.
                if (start) state_d = start_ok ? StSend : StFin;
            end
            StSend: begin
                if (hs && last_beat) begin
                    if (last_pkt)            state_d = StFin;
                    else if (GAP_CYCLES > 0) state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q + 32'd1 == GAP_CYCLES) state_d = StSend;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            nb_q    <= '0;
            beat_q  <= '0;
            empty_q <= '0;
            count_q <= '0;
            seq_q   <= '0;
            sent_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start_ok) begin
                nb_q    <= 16'((32'(packet_bytes) + BPB - 1) / BPB);
                empty_q <= 5'((16'(BPB) - packet_bytes % 16'(BPB)) % 16'(BPB));
                count_q <= packet_count;
                beat_q  <= '0;
                seq_q   <= '0;
                sent_q  <= '0;
            end
            if (hs) begin
                seq_q <= seq_q + 32'd1;
                if (last_beat) begin
                    beat_q <= '0;
                    sent_q <= sent_q + 32'd1;
                end else begin
                    beat_q <= beat_q + 16'd1;
                end
            end
            gap_q <= (state_q == StGap) ? gap_q + 32'd1 : 32'd0;
        end
    end

    assign AXIS_TX_TVALID = (state_q == StSend);
    assign AXIS_TX_TLAST  = (state_q == StSend) && last_beat;
    assign AXIS_TX_TUSER  = AXIS_TX_TLAST ? empty_q : 5'd0;
    assign AXIS_TX_TDATA  = {LANES{seq_q}};
    assign busy           = (state_q == StSend) || (state_q == StGap);
    assign done           = (state_q == StFin);
    assign packets_sent   = sent_q;

endmodule

// File: tb/tb_data_producer.sv
// Bench for data_producer: a back-to-back instance and a 3-cycle-gap instance,
// checked beat by beat against an arithmetic model of the expected stream.
module tb_data_producer;

    localparam int unsigned BPB = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start [2];
    logic [15:0] bytes;
    logic [31:0] count;
    logic        tready [2];
    logic        busy [2];
    logic        done [2];
    logic [31:0] psent [2];
    logic [127:0] tdata [2];
    logic [4:0]  tuser [2];
    logic        tlast [2];
    logic        tvalid [2];

    int unsigned m_bytes [2];
    int unsigned m_count [2];
    int unsigned m_k [2];
    int unsigned m_total [2];
    int unsigned m_hs_cyc [2];
    int          rmode [2];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        data_producer #(.DW(128), .GAP_CYCLES(gi * 3)) u_dut (
            .clk            (clk),
            .resetn         (resetn),
            .start          (start[gi]),
            .packet_bytes   (bytes),
            .packet_count   (count),
            .busy           (busy[gi]),
            .done           (done[gi]),
            .packets_sent   (psent[gi]),
            .AXIS_TX_TDATA  (tdata[gi]),
            .AXIS_TX_TUSER  (tuser[gi]),
            .AXIS_TX_TLAST  (tlast[gi]),
            .AXIS_TX_TVALID (tvalid[gi]),
            .AXIS_TX_TREADY (tready[gi])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ready pattern: always ready, or ready roughly 3 cycles in 8.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                tready[i] = (rmode[i] != 0) ? ($urandom_range(0, 7) < 3) : 1'b1;
        end
    end

    // Stream monitor: beat k of a run carries seq k; packet boundaries every NB beats.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        initial begin
            logic [127:0] held_data;
            logic [4:0]   held_user;
            logic         held_last;
            bit           stall = 0;
            bit           prev_last = 0;
            int unsigned  idle = 0;
            int unsigned  nb, k;
            bit           last;
            forever begin
                @(negedge clk);
                if (!resetn) begin
                    stall = 0;
                    idle  = 0;
                end else begin
                    if (stall) begin
                        check("stall_tvalid", tvalid[gi], 1'b1);
                        check("stall_tdata", tdata[gi], held_data);
                        check("stall_tuser", tuser[gi], held_user);
                        check("stall_tlast", tlast[gi], held_last);
                    end
                    if (tvalid[gi] && tready[gi]) begin
                        k  = m_k[gi];
                        nb = (m_bytes[gi] + BPB - 1) / BPB;
                        if (nb == 0) nb = 1;
                        last = (k % nb) == nb - 1;
                        check("beat_in_budget", k < m_total[gi], 1'b1);
                        check("tdata_seq", tdata[gi], {4{k}});
                        check("tlast", tlast[gi], last);
                        check("tuser", tuser[gi],
                              last ? 5'((BPB - m_bytes[gi] % BPB) % BPB) : 5'd0);
                        if (k > 0) check("idle_gap", idle, prev_last ? gi * 3 : 0);
                        prev_last    = last;
                        idle         = 0;
                        m_k[gi]      = k + 1;
                        m_hs_cyc[gi] = cyc;
                    end else if (!tvalid[gi]) begin
                        idle++;
                    end
                    stall     = tvalid[gi] && !tready[gi];
                    held_data = tdata[gi];
                    held_user = tuser[gi];
                    held_last = tlast[gi];
                end
            end
        end
    end

    task automatic start_run(input int i, input int unsigned b, input int unsigned c);
        @(posedge clk);
        #1;
        m_bytes[i] = b;
        m_count[i] = c;
        m_k[i]     = 0;
        m_total[i] = (b != 0 && c != 0) ? ((b + BPB - 1) / BPB) * c : 0;
        bytes      = 16'(b);
        count      = c;
        start[i]   = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        bytes    = 16'($urandom);
        count    = $urandom;
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        bit seen = 0;
        while (n < 4000 && !seen) begin
            @(negedge clk);
            n++;
            if (done[i]) seen = 1;
        end
        check("done_seen", seen, 1'b1);
        if (seen) begin
            check("all_beats_sent", m_k[i], m_total[i]);
            check("done_after_last_hs", cyc - m_hs_cyc[i], 1);
            check("busy_at_done", busy[i], 1'b0);
            check("tvalid_at_done", tvalid[i], 1'b0);
            check("packets_sent", psent[i], m_count[i]);
            @(negedge clk);
            check("done_one_cycle", done[i], 1'b0);
            check("packets_sent_hold", psent[i], m_count[i]);
        end
    endtask

    initial begin
        int unsigned b, c;
        int n;
        resetn = 1'b1;
        bytes  = '0;
        count  = '0;
        for (int i = 0; i < 2; i++) begin
            start[i]   = 1'b0;
            tready[i]  = 1'b1;
            rmode[i]   = 0;
            m_total[i] = 0;
            m_k[i]     = 0;
            m_bytes[i] = 1;
        end
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_tvalid", tvalid[i], 1'b0);
            check("rst_busy", busy[i], 1'b0);
            check("rst_done", done[i], 1'b0);
            check("rst_psent", psent[i], 32'd0);
            check("rst_tdata", tdata[i], 128'd0);
            check("rst_tlast", tlast[i], 1'b0);
        end
        resetn = 1'b1;

        // Back-to-back packets, then a ragged last beat.
        start_run(0, 64, 2);
        check("tvalid_after_start", tvalid[0], 1'b1);
        check("busy_after_start", busy[0], 1'b1);
        wait_done(0);
        start_run(0, 33, 1);
        wait_done(0);

        // Single-beat packets separated by the idle gap.
        start_run(1, 16, 3);
        check("tvalid_after_start_gap", tvalid[1], 1'b1);
        wait_done(1);

        // Random sizes under random backpressure on both instances.
        rmode[0] = 1;
        rmode[1] = 1;
        for (int t = 0; t < 8; t++) begin
            b = $urandom_range(1, 100);
            c = $urandom_range(1, 3);
            start_run(t % 2, b, c);
            wait_done(t % 2);
        end

        // A start during a run must not disturb it.
        start_run(0, 48, 2);
        repeat (2) @(posedge clk);
        #1;
        start[0] = 1'b1;
        bytes    = 16'd16;
        count    = 32'd5;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        check("busy_after_ignored_start", busy[0], 1'b1);
        wait_done(0);

        // Degenerate requests complete immediately with no beats.
        start_run(0, 40, 0);
        check("zero_count_done", done[0], 1'b1);
        check("zero_count_busy", busy[0], 1'b0);
        check("zero_count_tvalid", tvalid[0], 1'b0);
        @(posedge clk);
        #1;
        check("zero_count_done_clear", done[0], 1'b0);
        start_run(1, 0, 2);
        check("zero_bytes_done", done[1], 1'b1);
        check("zero_bytes_busy", busy[1], 1'b0);

        // Asynchronous reset in the middle of a run, then a fresh run.
        start_run(0, 160, 3);
        n = 0;
        while (n < 3000 && psent[0] == 0) begin
            @(negedge clk);
            n++;
        end
        check("reached_mid_run", psent[0] != 0 && busy[0], 1'b1);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_tvalid", tvalid[0], 1'b0);
        check("async_rst_busy", busy[0], 1'b0);
        check("async_rst_psent", psent[0], 32'd0);
        repeat (2) @(posedge clk);
        #2;
        resetn   = 1'b1;
        rmode[0] = 0;
        start_run(0, 32, 1);
        wait_done(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
